// File: rtl/reference_pulse_generator_pkg.sv
// Shared types and clamp helpers for the reference pulse generator.
package pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Helpers work on a wide type so any period width up to 64 bits can reuse them.
    typedef logic [63:0] clamp_t;

    localparam clamp_t MIN_PERIOD = clamp_t'(2);

    function automatic clamp_t clamp_period(input clamp_t period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

    // Keeps at least one inactive cycle per period so downstream edge detection always fires.
    function automatic clamp_t clamp_high(input clamp_t highTime, input clamp_t effPeriod);
        return (highTime >= effPeriod) ? effPeriod - clamp_t'(1) : highTime;
    endfunction

endpackage

// File: rtl/reference_pulse_generator_if.sv
// Control/status bundle of the reference pulse generator.
interface reference_pulse_generator_if #(
    parameter int PERIOD_WIDTH      = 32,
    parameter int PULSE_COUNT_WIDTH = 32
);
    logic                         enable;
    logic                         arm;
    logic                         start_trigger;
    logic [PERIOD_WIDTH-1:0]      period;
    logic [PERIOD_WIDTH-1:0]      high_time;
    logic [PULSE_COUNT_WIDTH-1:0] pulse_count;
    logic                         invert;
    logic                         pulse_out;
    logic                         running;
    logic                         armed;
    logic                         done;
    logic [PERIOD_WIDTH-1:0]      phase_counter;
    logic [PULSE_COUNT_WIDTH-1:0] pulses_emitted;

    modport master (
        output enable, arm, start_trigger, period, high_time, pulse_count, invert,
        input  pulse_out, running, armed, done, phase_counter, pulses_emitted
    );

    modport slave (
        input  enable, arm, start_trigger, period, high_time, pulse_count, invert,
        output pulse_out, running, armed, done, phase_counter, pulses_emitted
    );
endinterface

// File: rtl/reference_pulse_generator_rising_edge_detect.sv
// Registered rising-edge detector; clear_i zeroes the history register synchronously.
module rising_edge_detect (
    input  logic clk,
    input  logic aresetn,
    input  logic clear_i,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sig_q <= 1'b0;
        end else if (clear_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/reference_pulse_generator.sv
// Programmable periodic reference pulse source with armed start and finite bursts.
// Define PULSE_GEN_RETRIGGER_EN to let start_trigger edges re-phase a running train.
module reference_pulse_generator
    import pulse_gen_pkg::*;
#(
    parameter int PERIOD_WIDTH      = 32,
    parameter int PULSE_COUNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      aresetn,
    reference_pulse_generator_if.slave bus
);

    state_e                       state_q, state_d;
    logic [PERIOD_WIDTH-1:0]      phaseCounter_q, phaseCounter_d;
    logic [PERIOD_WIDTH-1:0]      shadowPeriod_q, shadowPeriod_d;
    logic [PERIOD_WIDTH-1:0]      shadowHigh_q, shadowHigh_d;
    logic [PULSE_COUNT_WIDTH-1:0] shadowCount_q, shadowCount_d;
    logic [PULSE_COUNT_WIDTH-1:0] pulsesEmitted_q, pulsesEmitted_d;
    logic                         rawPulse_q, rawPulse_d;

    logic                         startEdge;
    logic [PERIOD_WIDTH-1:0]      latchPeriod;
    logic [PERIOD_WIDTH-1:0]      latchHigh;
    logic                         atWrap;
    logic                         periodEnd;
    logic                         burstEnd;
    logic [PULSE_COUNT_WIDTH-1:0] emittedInc;

    rising_edge_detect uStartEdge (
        .clk     (clk),
        .aresetn (aresetn),
        .clear_i (~bus.enable),
        .sig_i   (bus.start_trigger),
        .rise_o  (startEdge)
    );

    assign latchPeriod = PERIOD_WIDTH'(clamp_period(clamp_t'(bus.period)));
    assign latchHigh   = PERIOD_WIDTH'(clamp_high(clamp_t'(bus.high_time), clamp_t'(latchPeriod)));

    assign atWrap     = (phaseCounter_q == shadowPeriod_q - PERIOD_WIDTH'(1));
    assign emittedInc = (&pulsesEmitted_q) ? pulsesEmitted_q
                                           : pulsesEmitted_q + PULSE_COUNT_WIDTH'(1);
    // Extra bit keeps the +1 from wrapping before the burst-length compare.
    assign burstEnd   = (shadowCount_q != '0) &&
                        (({1'b0, pulsesEmitted_q} + (PULSE_COUNT_WIDTH+1)'(1)) == {1'b0, shadowCount_q});

`ifdef PULSE_GEN_RETRIGGER_EN
    assign periodEnd = atWrap | startEdge;
`else
    assign periodEnd = atWrap;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q         <= IDLE;
            phaseCounter_q  <= '0;
            shadowPeriod_q  <= '0;
            shadowHigh_q    <= '0;
            shadowCount_q   <= '0;
            pulsesEmitted_q <= '0;
            rawPulse_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            phaseCounter_q  <= phaseCounter_d;
            shadowPeriod_q  <= shadowPeriod_d;
            shadowHigh_q    <= shadowHigh_d;
            shadowCount_q   <= shadowCount_d;
            pulsesEmitted_q <= pulsesEmitted_d;
            rawPulse_q      <= rawPulse_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        phaseCounter_d  = phaseCounter_q;
        shadowPeriod_d  = shadowPeriod_q;
        shadowHigh_d    = shadowHigh_q;
        shadowCount_d   = shadowCount_q;
        pulsesEmitted_d = pulsesEmitted_q;

        if (!bus.enable) begin
            state_d         = IDLE;
            phaseCounter_d  = '0;
            shadowPeriod_d  = '0;
            shadowHigh_d    = '0;
            shadowCount_d   = '0;
            pulsesEmitted_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (!bus.arm) begin
                        state_d = IDLE;
                    end else if (startEdge) begin
                        state_d         = RUN;
                        shadowPeriod_d  = latchPeriod;
                        shadowHigh_d    = latchHigh;
                        shadowCount_d   = bus.pulse_count;
                        phaseCounter_d  = '0;
                        pulsesEmitted_d = '0;
                    end
                end
                RUN: begin
                    // Period boundary is the only place new period/high values are adopted.
                    if (periodEnd) begin
                        phaseCounter_d  = '0;
                        pulsesEmitted_d = emittedInc;
                        shadowPeriod_d  = latchPeriod;
                        shadowHigh_d    = latchHigh;
                        if (burstEnd) begin
                            state_d = DONE;
                        end
                    end else begin
                        phaseCounter_d = phaseCounter_q + PERIOD_WIDTH'(1);
                    end
                end
                DONE: begin
                    if (!bus.arm) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rawPulse_d = (state_d == RUN) && (phaseCounter_d < shadowHigh_d);

    assign bus.pulse_out      = bus.invert ^ rawPulse_q;
    assign bus.running        = (state_q == RUN);
    assign bus.armed          = (state_q == ARMED);
    assign bus.done           = (state_q == DONE);
    assign bus.phase_counter  = phaseCounter_q;
    assign bus.pulses_emitted = pulsesEmitted_q;

endmodule

// File: tb/tb_reference_pulse_generator.sv
// Directed scoreboard bench for reference_pulse_generator.
// Retrigger expectations follow PULSE_GEN_RETRIGGER_EN when it is defined for the build.
module tb_reference_pulse_generator;

    localparam int PW = 32;
    localparam int CW = 32;

    typedef enum {SIG_PULSE, SIG_RUNNING, SIG_ARMED, SIG_DONE, SIG_PHASE, SIG_EMITTED} sigSel_e;
    typedef struct {
        string       tag;
        sigSel_e     sel;
        logic [31:0] value;
    } expect_t;

    logic    clk     = 1'b0;
    logic    aresetn = 1'b0;
    expect_t scoreboard[$];
    int      compared   = 0;
    int      mismatched = 0;

    reference_pulse_generator_if #(.PERIOD_WIDTH(PW), .PULSE_COUNT_WIDTH(CW)) bus ();

    reference_pulse_generator #(
        .PERIOD_WIDTH      (PW),
        .PULSE_COUNT_WIDTH (CW)
    ) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic armIn, input logic trig,
                                 input logic [PW-1:0] per, input logic [PW-1:0] high,
                                 input logic [CW-1:0] cnt, input logic inv);
        bus.enable        = en;
        bus.arm           = armIn;
        bus.start_trigger = trig;
        bus.period        = per;
        bus.high_time     = high;
        bus.pulse_count   = cnt;
        bus.invert        = inv;
    endtask

    task automatic expectNow(input string tag, input sigSel_e sel, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.sel   = sel;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    function automatic logic [31:0] observe(input sigSel_e sel);
        case (sel)
            SIG_PULSE:   return {31'b0, bus.pulse_out};
            SIG_RUNNING: return {31'b0, bus.running};
            SIG_ARMED:   return {31'b0, bus.armed};
            SIG_DONE:    return {31'b0, bus.done};
            SIG_PHASE:   return bus.phase_counter;
            default:     return bus.pulses_emitted;
        endcase
    endfunction

    task automatic checkOutput();
        while (scoreboard.size() > 0) begin
            expect_t     e;
            logic [31:0] obs;
            e   = scoreboard.pop_front();
            obs = observe(e.sel);
            compared++;
            assert (obs === e.value) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        repeat (2) tick();

        expectNow("rst_pulse",   SIG_PULSE,   0);
        expectNow("rst_running", SIG_RUNNING, 0);
        expectNow("rst_armed",   SIG_ARMED,   0);
        expectNow("rst_done",    SIG_DONE,    0);
        expectNow("rst_phase",   SIG_PHASE,   0);
        expectNow("rst_emitted", SIG_EMITTED, 0);
        checkOutput();
        aresetn = 1'b1;
        tick();

        $display("[TB] continuous train period=10 high=3");
        applyStimulus(1'b1, 1'b1, 1'b0, 10, 3, 0, 1'b0);
        tick();
        expectNow("cont_armed", SIG_ARMED, 1);
        checkOutput();
        bus.start_trigger = 1'b1;
        for (int k = 0; k <= 50; k++) begin
            tick();
            expectNow($sformatf("cont_pulse_k%0d", k),   SIG_PULSE,   32'((k % 10) < 3));
            expectNow($sformatf("cont_phase_k%0d", k),   SIG_PHASE,   32'(k % 10));
            expectNow($sformatf("cont_emitted_k%0d", k), SIG_EMITTED, 32'(k / 10));
            expectNow($sformatf("cont_running_k%0d", k), SIG_RUNNING, 1);
            checkOutput();
            if (k == 25) bus.arm = 1'b0;
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 10, 3, 0, 1'b0);
        tick();
        expectNow("dis_running", SIG_RUNNING, 0);
        expectNow("dis_phase",   SIG_PHASE,   0);
        expectNow("dis_emitted", SIG_EMITTED, 0);
        expectNow("dis_pulse",   SIG_PULSE,   0);
        checkOutput();

        $display("[TB] finite burst period=4 high=1 count=3");
        applyStimulus(1'b1, 1'b1, 1'b0, 4, 1, 3, 1'b0);
        tick();
        bus.start_trigger = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            expectNow($sformatf("burst_pulse_k%0d", k), SIG_PULSE,   32'((k % 4) == 0));
            expectNow($sformatf("burst_done_k%0d", k),  SIG_DONE,    0);
            checkOutput();
        end
        tick();
        expectNow("burst_done",    SIG_DONE,    1);
        expectNow("burst_running", SIG_RUNNING, 0);
        expectNow("burst_pulse",   SIG_PULSE,   0);
        expectNow("burst_emitted", SIG_EMITTED, 3);
        checkOutput();
        repeat (4) tick();
        expectNow("burst_hold_done",    SIG_DONE,    1);
        expectNow("burst_hold_pulse",   SIG_PULSE,   0);
        expectNow("burst_hold_emitted", SIG_EMITTED, 3);
        checkOutput();
        bus.arm           = 1'b0;
        bus.start_trigger = 1'b0;
        tick();
        expectNow("burst_idle_done",  SIG_DONE,  0);
        expectNow("burst_idle_armed", SIG_ARMED, 0);
        checkOutput();

        $display("[TB] clamps");
        applyStimulus(1'b0, 1'b0, 1'b0, 1, 5, 0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 1, 5, 0, 1'b0);
        tick();
        bus.start_trigger = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            expectNow($sformatf("clampP_pulse_k%0d", k), SIG_PULSE, 32'((k % 2) == 0));
            expectNow($sformatf("clampP_phase_k%0d", k), SIG_PHASE, 32'(k % 2));
            checkOutput();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8, 0, 0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 8, 0, 0, 1'b0);
        tick();
        bus.start_trigger = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            expectNow($sformatf("flat_pulse_k%0d", k), SIG_PULSE, 0);
            expectNow($sformatf("flat_phase_k%0d", k), SIG_PHASE, 32'(k % 8));
            checkOutput();
        end

        $display("[TB] period update at boundary and async abort");
        applyStimulus(1'b0, 1'b0, 1'b0, 10, 3, 0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 10, 3, 0, 1'b0);
        tick();
        bus.start_trigger = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            int ph;
            ph = (k < 10) ? k : ((k - 10) % 6);
            tick();
            expectNow($sformatf("upd_phase_k%0d", k),   SIG_PHASE,   32'(ph));
            expectNow($sformatf("upd_pulse_k%0d", k),   SIG_PULSE,   32'(ph < 3));
            expectNow($sformatf("upd_emitted_k%0d", k), SIG_EMITTED, (k < 10) ? 0 : ((k < 16) ? 1 : 2));
            checkOutput();
            if (k == 4) bus.period = 6;
        end
        bus.invert = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        expectNow("abort_running", SIG_RUNNING, 0);
        expectNow("abort_phase",   SIG_PHASE,   0);
        expectNow("abort_emitted", SIG_EMITTED, 0);
        expectNow("abort_pulse",   SIG_PULSE,   1);
        checkOutput();
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0, 20, 3, 0, 1'b0);
        aresetn = 1'b1;
        tick();

        $display("[TB] start edge while running");
        bus.arm = 1'b1;
        tick();
        bus.start_trigger = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            tick();
            expectNow($sformatf("retrig_phase_k%0d", k), SIG_PHASE, 32'(k));
            checkOutput();
            if (k == 5)  bus.start_trigger = 1'b0;
            if (k == 12) bus.start_trigger = 1'b1;
        end
        tick();
`ifdef PULSE_GEN_RETRIGGER_EN
        expectNow("retrig_phase",   SIG_PHASE,   0);
        expectNow("retrig_emitted", SIG_EMITTED, 1);
        expectNow("retrig_pulse",   SIG_PULSE,   1);
`else
        expectNow("retrig_phase",   SIG_PHASE,   13);
        expectNow("retrig_emitted", SIG_EMITTED, 0);
        expectNow("retrig_pulse",   SIG_PULSE,   0);
`endif
        checkOutput();

        $display("[TB] arm drop and start edge in the same cycle");
        applyStimulus(1'b0, 1'b0, 1'b0, 10, 3, 0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 10, 3, 0, 1'b0);
        tick();
        expectNow("race_armed_before", SIG_ARMED, 1);
        checkOutput();
        bus.arm           = 1'b0;
        bus.start_trigger = 1'b1;
        tick();
        expectNow("race_armed",   SIG_ARMED,   0);
        expectNow("race_running", SIG_RUNNING, 0);
        checkOutput();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
